// File: rtl/calckit_pkg.sv
//------------------------------------------------------------------------------
// Module  : calckit_pkg
// Brief   : Shared constants and FSM encoding for the timer session controller.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package calckit_pkg;

  localparam int unsigned TSC_TW           = 4;
  localparam int unsigned TSC_MIN_T        = 5;
  localparam int unsigned TSC_MAX_T        = 15;
  localparam int unsigned TSC_DEF_T        = 10;
  localparam int unsigned TSC_COOLDOWN_CYC = 4;

  localparam int unsigned REQ_ENTRY = 0;
  localparam int unsigned REQ_ERROR = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_RUN      = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_COOLDOWN = 3'd4
  } tsc_state_e;

endpackage

`default_nettype wire

// File: rtl/timer_session_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : timer_session_ctrl_if
// Brief   : Requester, configuration and timer signals of the session controller.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface timer_session_ctrl_if;
  import calckit_pkg::*;

  logic              cfg_inc_i;
  logic              cfg_dec_i;
  logic [1:0]        req_i;
  logic [TSC_TW-1:0] tmr_time_left_i;
  logic              tmr_done_i;
  logic              tmr_start_o;
  logic [TSC_TW-1:0] tmr_cfg_time_o;
  logic [TSC_TW-1:0] cfg_time_o;
  logic [1:0]        grant_o;
  logic              busy_o;
  logic [1:0]        timeout_o;
  logic [1:0]        early_done_o;
  logic [TSC_TW-1:0] left_at_finish_o;

  modport slave (
    input  cfg_inc_i, cfg_dec_i, req_i, tmr_time_left_i, tmr_done_i,
    output tmr_start_o, tmr_cfg_time_o, cfg_time_o, grant_o, busy_o,
           timeout_o, early_done_o, left_at_finish_o
  );

  modport master (
    output cfg_inc_i, cfg_dec_i, req_i, tmr_time_left_i, tmr_done_i,
    input  tmr_start_o, tmr_cfg_time_o, cfg_time_o, grant_o, busy_o,
           timeout_o, early_done_o, left_at_finish_o
  );

endinterface

`default_nettype wire

// File: rtl/tsc_dur_cfg.sv
//------------------------------------------------------------------------------
// Module  : tsc_dur_cfg
// Brief   : Saturating inc/dec register holding the user-configured duration.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tsc_dur_cfg
  import calckit_pkg::*;
#(
  parameter int unsigned MIN_T = TSC_MIN_T,
  parameter int unsigned MAX_T = TSC_MAX_T,
  parameter int unsigned DEF_T = TSC_DEF_T
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [TSC_TW-1:0] dur_o
);

  localparam logic [TSC_TW-1:0] MIN_V = TSC_TW'(MIN_T);
  localparam logic [TSC_TW-1:0] MAX_V = TSC_TW'(MAX_T);
  localparam logic [TSC_TW-1:0] DEF_V = TSC_TW'(DEF_T);

  logic [TSC_TW-1:0] dur_q, dur_d;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    dur_d = dur_q;
    if (inc_i && !dec_i && (dur_q < MAX_V)) begin
      dur_d = dur_q + 1'b1;
    end else if (dec_i && !inc_i && (dur_q > MIN_V)) begin
      dur_d = dur_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q <= DEF_V;
    end else begin
      dur_q <= dur_d;
    end
  end

  assign dur_o = dur_q;

endmodule

`default_nettype wire

// File: rtl/timer_session_ctrl.sv
//------------------------------------------------------------------------------
// Module  : timer_session_ctrl
// Brief   : Arbitrates the shared countdown timer between two requesters.
//           TSC_COOLDOWN_EN adds a COOLDOWN_CYC idle gap after each session.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_session_ctrl
  import calckit_pkg::*;
#(
  parameter int unsigned MIN_T = TSC_MIN_T,
  parameter int unsigned MAX_T = TSC_MAX_T,
  parameter int unsigned DEF_T = TSC_DEF_T
`ifdef TSC_COOLDOWN_EN
  , parameter int unsigned COOLDOWN_CYC = TSC_COOLDOWN_CYC
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  timer_session_ctrl_if.slave bus
);

  localparam logic [TSC_TW-1:0] DEF_V = TSC_TW'(DEF_T);

  tsc_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              tmr_start_q, tmr_start_d;
  logic [TSC_TW-1:0] tmr_cfg_q, tmr_cfg_d;
  logic [1:0]        timeout_q, timeout_d;
  logic [1:0]        early_q, early_d;
  logic [TSC_TW-1:0] left_q, left_d;
  logic              busy_q, busy_d;
  logic              rel_cnt_q, rel_cnt_d;
  logic [1:0]        blocked_q, blocked_d;
  logic [1:0]        eligible;
  logic [TSC_TW-1:0] cfg_time;

`ifdef TSC_COOLDOWN_EN
  localparam int unsigned CDW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  logic [CDW-1:0] cd_cnt_q, cd_cnt_d;
`endif

  tsc_dur_cfg #(
    .MIN_T (MIN_T),
    .MAX_T (MAX_T),
    .DEF_T (DEF_T)
  ) u_dur_cfg (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (bus.cfg_inc_i),
    .dec_i (bus.cfg_dec_i),
    .dur_o (cfg_time)
  );

  // A requester that timed out must drop req before it can be granted again.
  assign eligible = bus.req_i & ~blocked_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    tmr_start_d = tmr_start_q;
    tmr_cfg_d   = tmr_cfg_q;
    timeout_d   = 2'b00;
    early_d     = 2'b00;
    left_d      = left_q;
    rel_cnt_d   = rel_cnt_q;
    blocked_d   = blocked_q & bus.req_i;
`ifdef TSC_COOLDOWN_EN
    cd_cnt_d    = cd_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tmr_start_d = 1'b0;
        if (eligible[REQ_ENTRY]) begin
          grant_d   = 2'b01;
          tmr_cfg_d = cfg_time;
          state_d   = ST_ARM;
        end else if (eligible[REQ_ERROR]) begin
          grant_d   = 2'b10;
          tmr_cfg_d = cfg_time;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        tmr_start_d = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (bus.tmr_done_i) begin
          timeout_d   = grant_q;
          left_d      = '0;
          tmr_start_d = 1'b0;
          blocked_d   = blocked_d | grant_q;
          rel_cnt_d   = 1'b0;
          state_d     = ST_RELEASE;
        end else if ((bus.req_i & grant_q) == 2'b00) begin
          early_d     = grant_q;
          left_d      = bus.tmr_time_left_i;
          tmr_start_d = 1'b0;
          rel_cnt_d   = 1'b0;
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Two cycles of start low swallow any stray re-arm from the timer.
        tmr_start_d = 1'b0;
        if (rel_cnt_q) begin
          grant_d = 2'b00;
`ifdef TSC_COOLDOWN_EN
          cd_cnt_d = '0;
          state_d  = ST_COOLDOWN;
`else
          state_d  = ST_IDLE;
`endif
        end else begin
          rel_cnt_d = 1'b1;
        end
      end
`ifdef TSC_COOLDOWN_EN
      ST_COOLDOWN: begin
        if (cd_cnt_q == CDW'(COOLDOWN_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cd_cnt_d = cd_cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        grant_d     = 2'b00;
        tmr_start_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      tmr_start_q <= 1'b0;
      tmr_cfg_q   <= DEF_V;
      timeout_q   <= 2'b00;
      early_q     <= 2'b00;
      left_q      <= '0;
      busy_q      <= 1'b0;
      rel_cnt_q   <= 1'b0;
      blocked_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      tmr_start_q <= tmr_start_d;
      tmr_cfg_q   <= tmr_cfg_d;
      timeout_q   <= timeout_d;
      early_q     <= early_d;
      left_q      <= left_d;
      busy_q      <= busy_d;
      rel_cnt_q   <= rel_cnt_d;
      blocked_q   <= blocked_d;
    end
  end

`ifdef TSC_COOLDOWN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_cnt_q <= '0;
    end else begin
      cd_cnt_q <= cd_cnt_d;
    end
  end
`endif

  assign bus.tmr_start_o      = tmr_start_q;
  assign bus.tmr_cfg_time_o   = tmr_cfg_q;
  assign bus.cfg_time_o       = cfg_time;
  assign bus.grant_o          = grant_q;
  assign bus.busy_o           = busy_q;
  assign bus.timeout_o        = timeout_q;
  assign bus.early_done_o     = early_q;
  assign bus.left_at_finish_o = left_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_session_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_timer_session_ctrl
// Brief   : Directed self-checking bench with a behavioural 20-clk-second timer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_session_ctrl;
  import calckit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  timer_session_ctrl_if bus ();

  timer_session_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef TSC_COOLDOWN_EN
  localparam int GAP = 7;
`else
  localparam int GAP = 3;
`endif

  // Timer model: loads on start, counts down once per 20 clks, one done pulse.
  logic       m_run, m_fired, m_done, f_done;
  logic [3:0] m_left;
  logic [4:0] m_sub;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_fired <= 1'b0; m_done <= 1'b0; m_left <= 4'd0; m_sub <= 5'd0;
    end else begin
      m_done <= 1'b0;
      if (!bus.tmr_start_o) begin
        m_run <= 1'b0; m_fired <= 1'b0;
      end else if (!m_run && !m_fired) begin
        m_run <= 1'b1; m_left <= bus.tmr_cfg_time_o; m_sub <= 5'd0;
      end else if (m_run) begin
        if (m_sub == 5'd19) begin
          m_sub  <= 5'd0;
          m_left <= m_left - 4'd1;
          if (m_left == 4'd1) begin
            m_done <= 1'b1; m_run <= 1'b0; m_fired <= 1'b1;
          end
        end else begin
          m_sub <= m_sub + 5'd1;
        end
      end
    end
  end

  assign bus.tmr_done_i      = m_done | f_done;
  assign bus.tmr_time_left_i = m_left;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cfg(input logic inc, input logic dec);
    bus.cfg_inc_i = inc;
    bus.cfg_dec_i = dec;
    tick();
    bus.cfg_inc_i = 1'b0;
    bus.cfg_dec_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_total++;
    if (bus.cfg_time_o !== 4'd10 || bus.tmr_cfg_time_o !== 4'd10) $display("FAIL reset_cfg: got %0d/%0d expected 10/10", bus.cfg_time_o, bus.tmr_cfg_time_o);
    else n_pass++;
    n_total++;
    if ({bus.tmr_start_o, bus.grant_o, bus.busy_o} !== 4'b0000) $display("FAIL reset_ctrl: got start/grant/busy %b expected 0000", {bus.tmr_start_o, bus.grant_o, bus.busy_o});
    else n_pass++;
    n_total++;
    if ({bus.timeout_o, bus.early_done_o, bus.left_at_finish_o} !== 8'h00) $display("FAIL reset_status: got %h expected 00", {bus.timeout_o, bus.early_done_o, bus.left_at_finish_o});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cfg();
    for (int i = 0; i < 6; i++) pulse_cfg(1'b1, 1'b0);
    n_total++;
    if (bus.cfg_time_o !== 4'd15) $display("FAIL cfg_sat_max: got %0d expected 15", bus.cfg_time_o);
    else n_pass++;
    for (int i = 0; i < 11; i++) pulse_cfg(1'b0, 1'b1);
    n_total++;
    if (bus.cfg_time_o !== 4'd5) $display("FAIL cfg_sat_min: got %0d expected 5", bus.cfg_time_o);
    else n_pass++;
    pulse_cfg(1'b1, 1'b1);
    n_total++;
    if (bus.cfg_time_o !== 4'd5) $display("FAIL cfg_both: got %0d expected 5", bus.cfg_time_o);
    else n_pass++;
    pulse_cfg(1'b1, 1'b0);
    pulse_cfg(1'b1, 1'b0);
    n_total++;
    if (bus.cfg_time_o !== 4'd7) $display("FAIL cfg_inc: got %0d expected 7", bus.cfg_time_o);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    bus.req_i = 2'b11;
    tick();
    n_total++;
    if (bus.grant_o !== 2'b01 || bus.busy_o !== 1'b1 || bus.tmr_start_o !== 1'b0) $display("FAIL arb_grant: got grant %b busy %b start %b expected 01 1 0", bus.grant_o, bus.busy_o, bus.tmr_start_o);
    else n_pass++;
    n_total++;
    if (bus.tmr_cfg_time_o !== 4'd7) $display("FAIL arb_cfg: got %0d expected 7", bus.tmr_cfg_time_o);
    else n_pass++;
    tick();
    n_total++;
    if (bus.tmr_start_o !== 1'b1 || bus.grant_o !== 2'b01) $display("FAIL arb_start: got start %b grant %b expected 1 01", bus.tmr_start_o, bus.grant_o);
    else n_pass++;
    pulse_cfg(1'b1, 1'b0);
    n_total++;
    if (bus.cfg_time_o !== 4'd8 || bus.tmr_cfg_time_o !== 4'd7) $display("FAIL arb_frozen: got cfg %0d tmr_cfg %0d expected 8 7", bus.cfg_time_o, bus.tmr_cfg_time_o);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    while (bus.timeout_o == 2'b00 && n < 400) begin tick(); n++; end
    n_total++;
    if (bus.timeout_o !== 2'b01 || bus.left_at_finish_o !== 4'd0 || bus.tmr_start_o !== 1'b0) $display("FAIL to_pulse: got timeout %b left %0d start %b expected 01 0 0", bus.timeout_o, bus.left_at_finish_o, bus.tmr_start_o);
    else n_pass++;
    tick();
    n_total++;
    if (bus.timeout_o !== 2'b00 || bus.tmr_start_o !== 1'b0 || bus.grant_o !== 2'b01) $display("FAIL to_release: got timeout %b start %b grant %b expected 00 0 01", bus.timeout_o, bus.tmr_start_o, bus.grant_o);
    else n_pass++;
    n = 1;
    while (bus.grant_o != 2'b10 && n < 20) begin tick(); n++; end
    n_total++;
    if (n != GAP) $display("FAIL to_regrant_gap: got %0d clks expected %0d", n, GAP);
    else n_pass++;
  endtask

  task automatic test_rearm();
    for (int i = 0; i < 5; i++) tick();
    bus.req_i = 2'b01;
    tick();
    n_total++;
    if (bus.early_done_o !== 2'b10 || bus.left_at_finish_o !== 4'd8 || bus.timeout_o !== 2'b00) $display("FAIL rearm_early1: got early %b left %0d timeout %b expected 10 8 00", bus.early_done_o, bus.left_at_finish_o, bus.timeout_o);
    else n_pass++;
    for (int i = 0; i < 12; i++) tick();
    n_total++;
    if (bus.grant_o !== 2'b00 || bus.busy_o !== 1'b0) $display("FAIL rearm_blocked: got grant %b busy %b expected 00 0", bus.grant_o, bus.busy_o);
    else n_pass++;
    pulse_cfg(1'b1, 1'b0);
    pulse_cfg(1'b1, 1'b0);
    bus.req_i = 2'b00;
    tick();
    bus.req_i = 2'b01;
    tick();
    n_total++;
    if (bus.grant_o !== 2'b01 || bus.tmr_cfg_time_o !== 4'd10) $display("FAIL rearm_regrant: got grant %b cfg %0d expected 01 10", bus.grant_o, bus.tmr_cfg_time_o);
    else n_pass++;
  endtask

  task automatic test_early();
    int n;
    logic seen_to;
    n = 0;
    tick(); tick(); tick();
    while (!(m_run && m_left == 4'd4) && n < 400) begin tick(); n++; end
    bus.req_i = 2'b00;
    tick();
    n_total++;
    if (bus.early_done_o !== 2'b01 || bus.left_at_finish_o !== 4'd4 || bus.timeout_o !== 2'b00) $display("FAIL early_done: got early %b left %0d timeout %b expected 01 4 00", bus.early_done_o, bus.left_at_finish_o, bus.timeout_o);
    else n_pass++;
    seen_to = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (bus.timeout_o != 2'b00) seen_to = 1'b1;
    end
    n_total++;
    if (seen_to !== 1'b0) $display("FAIL early_no_timeout: got timeout seen %b expected 0", seen_to);
    else n_pass++;
  endtask

  task automatic test_race();
    bus.req_i = 2'b01;
    tick(); tick(); tick(); tick();
    bus.req_i = 2'b00;
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    n_total++;
    if (bus.timeout_o !== 2'b01 || bus.early_done_o !== 2'b00 || bus.left_at_finish_o !== 4'd0) $display("FAIL race: got timeout %b early %b left %0d expected 01 00 0", bus.timeout_o, bus.early_done_o, bus.left_at_finish_o);
    else n_pass++;
    for (int i = 0; i < 12; i++) tick();
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    n_total++;
    if (bus.grant_o !== 2'b00 || bus.timeout_o !== 2'b00 || bus.busy_o !== 1'b0) $display("FAIL done_idle: got grant %b timeout %b busy %b expected 00 00 0", bus.grant_o, bus.timeout_o, bus.busy_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bus.req_i = 2'b10;
    tick(); tick(); tick();
    n_total++;
    if (bus.tmr_start_o !== 1'b1 || bus.grant_o !== 2'b10) $display("FAIL midrun_pre: got start %b grant %b expected 1 10", bus.tmr_start_o, bus.grant_o);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.tmr_start_o !== 1'b0 || bus.grant_o !== 2'b00 || bus.busy_o !== 1'b0) $display("FAIL midrun_reset: got start %b grant %b busy %b expected 0 00 0", bus.tmr_start_o, bus.grant_o, bus.busy_o);
    else n_pass++;
    tick();
    bus.req_i = 2'b00;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.cfg_inc_i = 1'b0;
    bus.cfg_dec_i = 1'b0;
    bus.req_i     = 2'b00;
    f_done        = 1'b0;
    test_reset();
    test_cfg();
    test_arbitration();
    test_timeout();
    test_rearm();
    test_early();
    test_race();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
